// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external combinational ALU.
// One operation in flight at a time: accept in IDLE, capture the result in EXEC, hand it back in RESP.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_op_a,
    output logic [WIDTH-1:0] alu_op_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] LAST_LEGAL_OP = OPW'(6);

    state_t state;
    logic   grant;
    logic   last_grant;
    logic   pick;
    logic   accept;
    logic   done;

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return op <= LAST_LEGAL_OP;
    endfunction

    // Tie goes to the requester that was not served last; a lone request always wins.
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end else begin
            pick = req1_valid;
        end
    end

    assign accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !pick;
    assign req1_ready = accept && pick;

    assign rsp0_valid = !rst && (state == RESP) && !grant;
    assign rsp1_valid = !rst && (state == RESP) && grant;
    assign busy       = !rst && (state != IDLE);

    // Only the granted requester's ready can retire the response.
    assign done = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            alu_op_a   <= '0;
            alu_op_b   <= '0;
            alu_op     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant      <= pick;
                        last_grant <= pick;
                        alu_op_a   <= pick ? req1_a  : req0_a;
                        alu_op_b   <= pick ? req1_b  : req0_b;
                        alu_op     <= pick ? req1_op : req0_op;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_is_legal(alu_op)) begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                    end else begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_op_a, alu_op_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; illegal codes produce garbage that the arbiter must not forward.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_op_a, alu_op_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one outstanding job, result visible from one cycle after acceptance.
    logic             m_init = 1'b0;
    logic             m_have = 1'b0;
    logic             m_owner = 1'b0;
    logic             m_last = 1'b1;
    logic             m_pick;
    int               m_age = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_data = '0;
    logic [OPW-1:0]   m_op = '0;
    logic             m_err = 1'b0;
    logic             e_r0, e_r1, e_v0, e_v1, e_busy;

    always @(negedge clk) begin
        cyc++;
        m_pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; e_busy = 1'b0;
        if (!rst) begin
            if (!m_have) begin
                e_r0 = req0_valid && !m_pick;
                e_r1 = req1_valid && m_pick;
            end else begin
                e_busy = 1'b1;
                e_v0   = (m_age >= 1) && !m_owner;
                e_v1   = (m_age >= 1) && m_owner;
            end
        end
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("rsp0_valid", rsp0_valid, e_v0);
        chk("rsp1_valid", rsp1_valid, e_v1);
        chk("busy", busy, e_busy);
        if (m_init) begin
            chk("alu_op_a", alu_op_a, m_a);
            chk("alu_op_b", alu_op_b, m_b);
            chk("alu_op", alu_op, m_op);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", rsp_err, m_err);
        end
        if (rst) begin
            m_init = 1'b1; m_have = 1'b0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_err = 1'b0;
        end else if (!m_have) begin
            if (req0_valid || req1_valid) begin
                m_have  = 1'b1;
                m_owner = m_pick;
                m_last  = m_pick;
                m_age   = 0;
                m_a  = m_pick ? req1_a  : req0_a;
                m_b  = m_pick ? req1_b  : req0_b;
                m_op = m_pick ? req1_op : req0_op;
            end
        end else if (m_age == 0) begin
            m_age  = 1;
            m_err  = (m_op > 4'd6);
            m_data = m_err ? '0 : ref_alu(m_a, m_b, m_op);
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_have = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(output int g);
        g = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin g = 0; break; end
            if (req1_ready) begin g = 1; break; end
            tick();
        end
        if (g < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ready: no grant within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        tick(); tick();
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_alu_op_a", alu_op_a, 32'd0);
        rst = 1'b0;

        // Single ADD on requester 0
        req0_valid = 1; req0_a = 10; req0_b = 5; req0_op = 4'd0; rsp0_ready = 1;
        #1;
        chk("s1_req0_ready", req0_ready, 1'b1);
        chk("s1_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 0;
        #1;
        chk("s1_busy_exec", busy, 1'b1);
        chk("s1_no_early_rsp", rsp0_valid, 1'b0);
        chk("s1_alu_a", alu_op_a, 32'd10);
        tick(); #1;
        chk("s1_rsp0_valid", rsp0_valid, 1'b1);
        chk("s1_data", rsp_data, 32'd15);
        chk("s1_err", rsp_err, 1'b0);
        chk("s1_busy_resp", busy, 1'b1);
        tick(); #1;
        chk("s1_idle_busy", busy, 1'b0);
        chk("s1_idle_valid", rsp0_valid, 1'b0);

        // Continuous contention after reset: grants 0,1,0,1
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_a = 10; req0_b = 5; req0_op = 4'd1;
        req1_valid = 1; req1_a = 1;  req1_b = 5; req1_op = 4'd5;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(g);
            chk("s2_grant", g, k % 2);
            tick(); tick(); #1;
            chk("s2_data", rsp_data, (k % 2) ? 32'd32 : 32'd5);
            chk("s2_valid", (k % 2) ? rsp1_valid : rsp0_valid, 1'b1);
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure on requester 1 while requester 0 waits
        rsp1_ready = 0;
        req1_valid = 1; req1_a = 32'hAAAA5555; req1_b = 32'hFFFF0000; req1_op = 4'd4;
        wait_ready(g);
        chk("s3_grant", g, 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 4'd0; rsp0_ready = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s3_rsp1_held", rsp1_valid, 1'b1);
            chk("s3_data_stable", rsp_data, 32'h55555555);
            chk("s3_no_accept", req0_ready, 1'b0);
            tick();
        end
        rsp1_ready = 1;
        tick();
        wait_ready(g);
        chk("s3_waiter_grant", g, 0);
        tick();
        req0_valid = 0;
        tick(); #1;
        chk("s3_waiter_data", rsp_data, 32'd7);
        tick();

        // Opcode table including illegal codes and the legal boundary
        tbl[0] = '{4'hF, 32'd9, 32'd9, 32'd0, 1'b1};
        tbl[1] = '{4'h7, 32'd9, 32'd9, 32'd0, 1'b1};
        tbl[2] = '{4'h6, 32'h80000000, 32'd31, 32'd1, 1'b0};
        tbl[3] = '{4'h2, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        tbl[4] = '{4'h3, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0};
        tbl[5] = '{4'h1, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0};
        tbl[6] = '{4'h0, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0};
        rsp0_ready = 1;
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_op = tbl[i].op;
            wait_ready(g);
            chk("s4_grant", g, 0);
            tick();
            req0_valid = 0;
            tick(); #1;
            chk("s4_valid", rsp0_valid, 1'b1);
            chk("s4_data", rsp_data, tbl[i].data);
            chk("s4_err", rsp_err, tbl[i].err);
            tick();
        end

        // Reset while a response is pending
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 4'd0;
        wait_ready(g);
        tick();
        req0_valid = 0;
        tick(); #1;
        chk("s5_pending", rsp0_valid, 1'b1);
        rst = 1;
        #1;
        chk("s5_valid_in_rst", rsp0_valid, 1'b0);
        chk("s5_busy_in_rst", busy, 1'b0);
        tick();
        chk("s5_data_reset", rsp_data, 32'd0);
        chk("s5_alu_op_reset", alu_op, 4'd0);
        chk("s5_alu_b_reset", alu_op_b, 32'd0);
        rst = 0;
        req1_valid = 1; req1_a = 256; req1_b = 2; req1_op = 4'd6; rsp1_ready = 1;
        wait_ready(g);
        chk("s5_grant", g, 1);
        tick();
        req1_valid = 0;
        tick(); #1;
        chk("s5_srl", rsp_data, 32'd64);
        tick();

        // Ready from the wrong port is ignored
        rsp0_ready = 0; rsp1_ready = 1;
        req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 4'd0;
        wait_ready(g);
        tick();
        req0_valid = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("s6_rsp0_held", rsp0_valid, 1'b1);
            chk("s6_rsp1_low", rsp1_valid, 1'b0);
            chk("s6_data", rsp_data, 32'd4);
            tick();
        end
        rsp0_ready = 1;
        tick(); #1;
        chk("s6_done", busy, 1'b0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, 32, operand/result width.
REQ-002 Parameter OPW, 4, opcode width; codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  out  1  requester n operation accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands of requester n.
REQ-008 req0_op / req1_op  in  OPW  opcode of requester n.
REQ-009 rsp0_valid / rsp1_valid  out  1  result available to requester n.
REQ-010 rsp0_ready / rsp1_ready  in  1  requester n consumes result.
REQ-011 rsp_data  out  WIDTH  result, shared by both response ports.
REQ-012 rsp_err  out  1  opcode was illegal (> 0110).
REQ-013 alu_op_a, alu_op_b  out  WIDTH  operands driven to the external combinational ALU.
REQ-014 alu_op  out  OPW  opcode driven to the external ALU.
REQ-015 alu_result  in  WIDTH  combinational ALU output.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; one transition per cycle maximum.
REQ-018 IDLE: with any reqN_valid high, grant one requester; in the same cycle assert only that reqN_ready (combinational), register its a/b/op into alu_op_a/alu_op_b/alu_op and its index into grant, and go to EXEC.
REQ-019 IDLE with no valid requests: stay in IDLE; both req_ready low.
REQ-020 Arbitration is round-robin. A 1-bit last_grant register decides ties: both valid -> grant the requester not equal to last_grant. A single valid -> grant that requester regardless of last_grant.
REQ-021 last_grant updates to grant when the request is accepted.
REQ-022 EXEC: register alu_result into rsp_data with rsp_err=0 if alu_op <= 0110. Otherwise rsp_data=0 and rsp_err=1. Go to RESP.
REQ-023 RESP: assert rspN_valid for the granted requester only. Hold rsp_data/rsp_err stable until rspN_ready.
REQ-024 RESP with rspN_ready high: that cycle completes the transfer; go to IDLE; rspN_valid low from the next cycle.
REQ-025 Latency: accept at cycle N -> rspN_valid at N+2 at the earliest. Minimum issue interval is 3 cycles.
REQ-026 req_ready is never asserted outside IDLE; requests arriving in EXEC/RESP wait and remain valid (requester obligation).
REQ-027 rspN_ready from the non-granted requester is ignored.
REQ-028 rspN_ready high while rspN_valid is low has no effect.
REQ-029 alu_op_a/alu_op_b/alu_op hold their last captured values until the next accept; no ALU operand change during EXEC or RESP.
REQ-030 Arithmetic (wrap, shift amount) is defined by the external ALU. This block passes values unmodified at full WIDTH.

Reset
REQ-031 rst high at a clock edge forces the following, regardless of state, including mid-EXEC/RESP, where the pending result is discarded: state=IDLE, last_grant=1 (requester 0 wins the first tie), alu_op_a=0, alu_op_b=0, alu_op=0, rsp_data=0, rsp_err=0.
REQ-032 While rst is high: req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy all 0.

Verification
REQ-033 Single request: req0 ADD a=10 b=5, rsp0_ready=1 -> req0_ready at cycle N, rsp0_valid at N+2 with rsp_data=15, rsp_err=0, busy high N+1..N+2.
REQ-034 Tie after reset: both valid, req0 SUB 10,5 and req1 SLL 1,5 -> req0 served first (rsp_data=5), then req1 (rsp_data=32). Grants alternate 0,1,0,1 under continuous contention.
REQ-035 Backpressure: req1 XOR 0xAAAA5555,0xFFFF0000 with rsp1_ready low 4 cycles -> rsp1_valid held, rsp_data stable 0x55555555, no new accept until consumed.
REQ-036 Illegal op: req0_op=1111 -> rsp0_valid with rsp_data=0, rsp_err=1.
REQ-037 Reset mid-RESP: assert rst during rsp0_valid -> next cycle all outputs at reset values. Subsequent req1 SRL 256,2 returns 64.
REQ-038 Wrong-port ready: in RESP for requester 0, rsp1_ready=1 and rsp0_ready=0 -> state stays RESP, rsp0_valid remains high.
